blue_sprite_addr: RTL



---
 rtl/blue_sprite_addr_pkg.sv | 30 +++
 rtl/blue_sprite_addr_anim_seq.sv | 79 +++++++
 rtl/blue_sprite_addr.sv | 114 +++++++++++
 3 files changed

// File: rtl/blue_sprite_addr_pkg.sv
// ---------------------------------------------------------------------------
// blue_sprite_addr_pkg
// Shared definitions for the character sprite address / animation blocks and
// the downstream display stage.
//   anim_e        : animation selector encoding (STATIC / WALK_R / WALK_L)
//   SPR_W_DEF     : default sprite width in pixels
//   SPR_H_DEF     : default sprite height in pixels
//   ANIM_FRAMES   : number of frames in every animation loop
// ---------------------------------------------------------------------------
package blue_sprite_addr_pkg;

    typedef enum logic [1:0] {
        ANIM_STATIC = 2'd0,
        ANIM_WALK_R = 2'd1,
        ANIM_WALK_L = 2'd2
    } anim_e;

    localparam int SPR_W_DEF   = 40;
    localparam int SPR_H_DEF   = 40;
    localparam int ANIM_FRAMES = 4;

    // Map the two direction keys onto the requested animation. Both held or
    // both released means the character stands still.
    function automatic anim_e decode_req(input logic move_left, input logic move_right);
        if (move_left == move_right) return ANIM_STATIC;
        else if (move_right)         return ANIM_WALK_R;
        else                         return ANIM_WALK_L;
    endfunction

endpackage

// File: rtl/blue_sprite_addr_anim_seq.sv
// ---------------------------------------------------------------------------
// blue_sprite_addr_anim_seq
// Animation sequencer: decodes the key request, holds the live animation
// state, divides the clock down to the frame rate and steps a 4-frame counter.
//   clk, rst       : clock, synchronous active-high reset
//   move_left_i    : left key held
//   move_right_i   : right key held
//   cur_st_o       : live animation state
//   live_fr_o      : live frame index 0..3
//   frame_tick_o   : one-cycle pulse, high in the cycle live_fr_o has just advanced
// ---------------------------------------------------------------------------
module blue_sprite_addr_anim_seq
    import blue_sprite_addr_pkg::*;
#(
    parameter int FRAME_DIV = 6000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_left_i,
    input  logic       move_right_i,
    output anim_e      cur_st_o,
    output logic [1:0] live_fr_o,
    output logic       frame_tick_o
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    anim_e            req;
    anim_e            cur_st_q, cur_st_d;
    logic [1:0]       live_fr_q, live_fr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        req       = decode_req(move_left_i, move_right_i);
        cur_st_d  = cur_st_q;
        live_fr_d = live_fr_q;
        div_d     = div_q;
        tick_d    = 1'b0;

        if (req != cur_st_q) begin
            // A new request restarts the animation from frame 0; it also wins
            // over a coincident divider terminal count, so no tick is issued.
            cur_st_d  = req;
            live_fr_d = 2'd0;
            div_d     = '0;
        end else if (div_q == DIV_LAST) begin
            div_d     = '0;
            live_fr_d = live_fr_q + 2'd1;
            tick_d    = 1'b1;
        end else begin
            div_d     = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            cur_st_q  <= ANIM_STATIC;
            live_fr_q <= 2'd0;
            div_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            cur_st_q  <= cur_st_d;
            live_fr_q <= live_fr_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
        end
    end

    assign cur_st_o     = cur_st_q;
    assign live_fr_o    = live_fr_q;
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/blue_sprite_addr.sv
// ---------------------------------------------------------------------------
// blue_sprite_addr
// Address generation for the blue character sprite: registered ROM address
// and in-box flag for the current scan position, plus the animation selector
// and frame index latched once per video frame at scan point (0,0).
//   clk, rst     : clock, synchronous active-high reset
//   h_cnt, v_cnt : current VGA scan column / row
//   pos_x, pos_y : sprite top-left corner
//   move_left    : left key held
//   move_right   : right key held
//   sprite_addr  : ROM address for the scan pixel (0 outside the box), 1 cycle
//   sprite_hit   : scan pixel inside sprite box, aligned with sprite_addr
//   sprite_hit_d : sprite_hit delayed one cycle, aligned with ROM data
//   anim_sel     : displayed animation (anim_e encoding)
//   frame_idx    : displayed frame 0..3
//   frame_tick   : pulse when the live frame counter advances
// ---------------------------------------------------------------------------
module blue_sprite_addr
    import blue_sprite_addr_pkg::*;
#(
    parameter int SPR_W     = SPR_W_DEF,
    parameter int SPR_H     = SPR_H_DEF,
    parameter int ADDR_W    = 11,
    parameter int FRAME_DIV = 6000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              move_left,
    input  logic              move_right,
    output logic [ADDR_W-1:0] sprite_addr,
    output logic              sprite_hit,
    output logic              sprite_hit_d,
    output logic [1:0]        anim_sel,
    output logic [1:0]        frame_idx,
    output logic              frame_tick
);

    anim_e      cur_st;
    logic [1:0] live_fr;

    blue_sprite_addr_anim_seq #(
        .FRAME_DIV (FRAME_DIV)
    ) u_anim_seq (
        .clk          (clk),
        .rst          (rst),
        .move_left_i  (move_left),
        .move_right_i (move_right),
        .cur_st_o     (cur_st),
        .live_fr_o    (live_fr),
        .frame_tick_o (frame_tick)
    );

    // ---------------- hit test and address ----------------
    logic [10:0]       x_lo, x_hi, y_lo, y_hi, h_ext, v_ext;
    logic              hit_d;
    logic [9:0]        col, row, col_m;
    logic [ADDR_W-1:0] addr_d;

    anim_e             anim_sel_q;
    logic [1:0]        frame_idx_q;
    logic              hit_q, hit_dly_q;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        // Box bounds are formed at 11 bits so a sprite near the right/bottom
        // edge cannot wrap its far bound back into the low columns.
        h_ext = {1'b0, h_cnt};
        v_ext = {1'b0, v_cnt};
        x_lo  = {1'b0, pos_x};
        y_lo  = {1'b0, pos_y};
        x_hi  = x_lo + 11'(SPR_W);
        y_hi  = y_lo + 11'(SPR_H);
        hit_d = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);

        col = h_cnt - pos_x;
        row = v_cnt - pos_y;
        // Walking left reuses the walk-right frames mirrored. The latched
        // selector is used so the mirror only flips at a frame boundary.
        col_m = (anim_sel_q == ANIM_WALK_L) ? (10'(SPR_W - 1) - col) : col;

        addr_d = hit_d ? (ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_m)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            hit_q       <= 1'b0;
            hit_dly_q   <= 1'b0;
            anim_sel_q  <= ANIM_STATIC;
            frame_idx_q <= 2'd0;
        end else begin
            addr_q    <= addr_d;
            hit_q     <= hit_d;
            hit_dly_q <= hit_q;
            // Display selection changes only at the top-left scan point so a
            // frame is never drawn half in one pose and half in another.
            if ((h_cnt == 10'd0) && (v_cnt == 10'd0)) begin
                anim_sel_q  <= cur_st;
                frame_idx_q <= live_fr;
            end
        end
    end

    assign sprite_addr  = addr_q;
    assign sprite_hit   = hit_q;
    assign sprite_hit_d = hit_dly_q;
    assign anim_sel     = anim_sel_q;
    assign frame_idx    = frame_idx_q;

endmodule
